// File: rtl/predicate_rf_pkg.sv
// Shared types and default sizes for the per-warp predicate register file.
package predicate_rf_pkg;

  localparam int DEF_NUM_LANES = 8;
  localparam int DEF_NUM_WARPS = 16;
  localparam int DEF_NUM_PREGS = 16;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/pred_rf_sweep_ctrl.sv
// Sequencer for the predicate file: post-reset zeroing sweep over every row, then
// per-warp bulk clear on request. Drives the row to zero and the ready/busy/done flags.
//
//  state   | meaning
//  S_INIT  | zeroing all rows warp-major after reset, user traffic dropped
//  S_IDLE  | reads/writes/clear requests accepted
//  S_CLEAR | zeroing rows 0..NUM_PREGS-1 of the latched warp
module pred_rf_sweep_ctrl
  import predicate_rf_pkg::*;
#(
  parameter int NUM_WARPS = DEF_NUM_WARPS,
  parameter int NUM_PREGS = DEF_NUM_PREGS,
  parameter int WARP_W    = $clog2(NUM_WARPS),
  parameter int PREG_W    = $clog2(NUM_PREGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr_req,
  input  logic [WARP_W-1:0] i_clr_warp,
  output logic [WARP_W-1:0] o_sweep_warp,
  output logic [PREG_W-1:0] o_sweep_row,
  output logic              o_sweep_we,
  output logic              o_ready,
  output logic              o_clr_busy,
  output logic              o_clr_done
);

  state_e            r_state;
  logic [WARP_W-1:0] r_warp;
  logic [PREG_W-1:0] r_row;
  logic              w_row_last;
  logic              w_warp_last;

  assign w_row_last  = (int'(r_row) == NUM_PREGS - 1);
  assign w_warp_last = (int'(r_warp) == NUM_WARPS - 1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_INIT;
      r_warp  <= '0;
      r_row   <= '0;
    end else begin
      case (r_state)
        S_INIT: begin
          if (w_row_last) begin
            r_row <= '0;
            if (w_warp_last) begin
              r_state <= S_IDLE;
              r_warp  <= '0;
            end else begin
              r_warp <= r_warp + WARP_W'(1);
            end
          end else begin
            r_row <= r_row + PREG_W'(1);
          end
        end
        S_IDLE: begin
          if (i_clr_req) begin
            r_state <= S_CLEAR;
            r_warp  <= i_clr_warp;
            r_row   <= '0;
          end
        end
        S_CLEAR: begin
          if (w_row_last) begin
            r_state <= S_IDLE;
            r_row   <= '0;
          end else begin
            r_row <= r_row + PREG_W'(1);
          end
        end
        default: begin
          r_state <= S_INIT;
          r_warp  <= '0;
          r_row   <= '0;
        end
      endcase
    end
  end

  assign o_sweep_warp = r_warp;
  assign o_sweep_row  = r_row;
  assign o_sweep_we   = (r_state == S_INIT) || (r_state == S_CLEAR);
  assign o_ready      = (r_state == S_IDLE);
  assign o_clr_busy   = (r_state == S_CLEAR);
  assign o_clr_done   = (r_state == S_CLEAR) && w_row_last;

endmodule

// File: rtl/predicate_register_file_param.sv
// Per-warp predicate register file: lane-masked write port, two registered read ports,
// sweep-driven init/clear. Define PRED_BYPASS_EN to forward same-cycle writes to reads.
module predicate_register_file_param
  import predicate_rf_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int NUM_WARPS = DEF_NUM_WARPS,
  parameter int NUM_PREGS = DEF_NUM_PREGS,
  parameter int WARP_W    = $clog2(NUM_WARPS),
  parameter int PREG_W    = $clog2(NUM_PREGS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  output logic                 o_ready,
  input  logic [WARP_W-1:0]    i_rd_warp,
  input  logic [NUM_LANES-1:0] i_rd_en_0,
  input  logic [PREG_W-1:0]    i_rd_addr_0,
  input  logic [NUM_LANES-1:0] i_rd_en_1,
  input  logic [PREG_W-1:0]    i_rd_addr_1,
  output logic [NUM_LANES-1:0] o_rd_data_0,
  output logic [NUM_LANES-1:0] o_rd_data_1,
  output logic                 o_rd_valid_0,
  output logic                 o_rd_valid_1,
  input  logic [WARP_W-1:0]    i_wr_warp,
  input  logic [PREG_W-1:0]    i_wr_addr,
  input  logic [NUM_LANES-1:0] i_wr_en,
  input  logic [NUM_LANES-1:0] i_wr_data,
  input  logic                 i_clr_req,
  input  logic [WARP_W-1:0]    i_clr_warp,
  output logic                 o_clr_busy,
  output logic                 o_clr_done
);

  localparam int ROWS  = NUM_WARPS * NUM_PREGS;
  localparam int IDX_W = $clog2(ROWS);

  function automatic logic [IDX_W-1:0] row_idx(input logic [WARP_W-1:0] w,
                                               input logic [PREG_W-1:0] p);
    return IDX_W'(int'(w) * NUM_PREGS + int'(p));
  endfunction

  function automatic logic in_range(input logic [WARP_W-1:0] w, input logic [PREG_W-1:0] p);
    return (int'(w) < NUM_WARPS) && (int'(p) < NUM_PREGS);
  endfunction

  logic [NUM_LANES-1:0] r_mem [ROWS];
  logic [NUM_LANES-1:0] r_rd_data_0, r_rd_data_1;
  logic                 r_rd_valid_0, r_rd_valid_1;

  logic [WARP_W-1:0]    w_sweep_warp;
  logic [PREG_W-1:0]    w_sweep_row;
  logic                 w_sweep_we;
  logic                 w_ready;

  logic                 w_wr_act;
  logic [IDX_W-1:0]     w_wr_idx, w_rd_idx_0, w_rd_idx_1;
  logic                 w_rd_ok_0, w_rd_ok_1;
  logic [NUM_LANES-1:0] w_rd_row_0, w_rd_row_1;

  logic                 w_mem_we;
  logic [IDX_W-1:0]     w_mem_idx;
  logic [NUM_LANES-1:0] w_mem_mask, w_mem_data;

  pred_rf_sweep_ctrl #(
    .NUM_WARPS (NUM_WARPS),
    .NUM_PREGS (NUM_PREGS),
    .WARP_W    (WARP_W),
    .PREG_W    (PREG_W)
  ) u_sweep (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_clr_req    (i_clr_req),
    .i_clr_warp   (i_clr_warp),
    .o_sweep_warp (w_sweep_warp),
    .o_sweep_row  (w_sweep_row),
    .o_sweep_we   (w_sweep_we),
    .o_ready      (w_ready),
    .o_clr_busy   (o_clr_busy),
    .o_clr_done   (o_clr_done)
  );

  assign w_wr_idx   = row_idx(i_wr_warp, i_wr_addr);
  assign w_wr_act   = w_ready && in_range(i_wr_warp, i_wr_addr) && (|i_wr_en);
  assign w_rd_idx_0 = row_idx(i_rd_warp, i_rd_addr_0);
  assign w_rd_idx_1 = row_idx(i_rd_warp, i_rd_addr_1);
  assign w_rd_ok_0  = in_range(i_rd_warp, i_rd_addr_0);
  assign w_rd_ok_1  = in_range(i_rd_warp, i_rd_addr_1);

  // Sweep and user writes never overlap: the sweep only runs while not ready.
  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_idx  = w_wr_idx;
    w_mem_mask = i_wr_en;
    w_mem_data = i_wr_data;
    if (w_sweep_we) begin
      w_mem_we   = (int'(w_sweep_warp) < NUM_WARPS);
      w_mem_idx  = row_idx(w_sweep_warp, w_sweep_row);
      w_mem_mask = '1;
      w_mem_data = '0;
    end else if (w_wr_act) begin
      w_mem_we = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_mem_we)
      r_mem[w_mem_idx] <= (r_mem[w_mem_idx] & ~w_mem_mask) | (w_mem_data & w_mem_mask);
  end

  always_comb begin
    w_rd_row_0 = '0;
    w_rd_row_1 = '0;
    if (w_rd_ok_0) w_rd_row_0 = r_mem[w_rd_idx_0];
    if (w_rd_ok_1) w_rd_row_1 = r_mem[w_rd_idx_1];
`ifdef PRED_BYPASS_EN
    if (w_wr_act && w_rd_ok_0 && (w_rd_idx_0 == w_wr_idx))
      w_rd_row_0 = (w_rd_row_0 & ~i_wr_en) | (i_wr_data & i_wr_en);
    if (w_wr_act && w_rd_ok_1 && (w_rd_idx_1 == w_wr_idx))
      w_rd_row_1 = (w_rd_row_1 & ~i_wr_en) | (i_wr_data & i_wr_en);
`endif
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data_0  <= '0;
      r_rd_data_1  <= '0;
      r_rd_valid_0 <= 1'b0;
      r_rd_valid_1 <= 1'b0;
    end else begin
      r_rd_valid_0 <= w_ready && (|i_rd_en_0);
      r_rd_valid_1 <= w_ready && (|i_rd_en_1);
      r_rd_data_0  <= w_ready ? (w_rd_row_0 & i_rd_en_0) : '0;
      r_rd_data_1  <= w_ready ? (w_rd_row_1 & i_rd_en_1) : '0;
    end
  end

  assign o_ready      = w_ready;
  assign o_rd_data_0  = r_rd_data_0;
  assign o_rd_data_1  = r_rd_data_1;
  assign o_rd_valid_0 = r_rd_valid_0;
  assign o_rd_valid_1 = r_rd_valid_1;

endmodule
